wbx_arbiter: RTL and testbench

WBX_ARBITER -- requirements
Module: wbx_arbiter

---
 rtl/wbx_pkg.sv | 7 +
 rtl/wbx_rr_pick.sv | 25 ++
 rtl/wbx_arbiter.sv | 95 +++++++++
 tb/tb_wbx_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/wbx_pkg.sv
// wbx_pkg: Wishbone field widths and arbiter state encoding shared by the wbx arbiter files.
package wbx_pkg;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    typedef enum logic {IDLE, OWNED} state_e;
endpackage

// File: rtl/wbx_rr_pick.sv
// wbx_rr_pick: combinational round-robin pick, nearest requester after last wins.
module wbx_rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          valid
);
    int pos;
    // Scan from farthest to nearest so the nearest requester is written last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int d = N; d >= 1; d--) begin
            pos = (int'(last) + d) % N;
            if (req[pos]) begin
                idx   = IW'(pos);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wbx_arbiter.sv
// wbx_arbiter: round-robin arbiter sharing one Wishbone B4 pipelined slave among MASTER_NUM masters,
// with a cap on accepted-but-unacknowledged transfers.
module wbx_arbiter
    import wbx_pkg::*;
#(
    parameter int MASTER_NUM  = 2,
    parameter int MAX_PENDING = 4
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [MASTER_NUM-1:0]       wbm_cyc_o,
    input  logic [MASTER_NUM-1:0]       wbm_stb_o,
    input  logic [MASTER_NUM-1:0]       wbm_we_o,
    input  logic [ADR_W*MASTER_NUM-1:0] wbm_adr_o,
    input  logic [SEL_W*MASTER_NUM-1:0] wbm_sel_o,
    input  logic [DAT_W*MASTER_NUM-1:0] wbm_dat_o,
    output logic [DAT_W-1:0]            wbm_dat_i,
    output logic [MASTER_NUM-1:0]       wbm_stall_i,
    output logic [MASTER_NUM-1:0]       wbm_ack_i,
    output logic                        wbs_cyc_i,
    output logic                        wbs_stb_i,
    output logic                        wbs_we_i,
    output logic [ADR_W-1:0]            wbs_adr_i,
    output logic [SEL_W-1:0]            wbs_sel_i,
    output logic [DAT_W-1:0]            wbs_dat_i,
    input  logic [DAT_W-1:0]            wbs_dat_o,
    input  logic                        wbs_stall_o,
    input  logic                        wbs_ack_o
);
    localparam int IW = $clog2(MASTER_NUM);
    localparam int PW = $clog2(MAX_PENDING + 1);

    state_e        state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d, last_q, last_d, pick_idx;
    logic [PW-1:0] pending_q, pending_d;
    logic          pick_valid, owned, cyc_g, full, accept, retire;

    wbx_rr_pick #(.N(MASTER_NUM), .IW(IW)) u_pick (
        .req   (wbm_cyc_o),
        .last  (last_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owned     = state_q == OWNED;
    assign cyc_g     = wbm_cyc_o[gnt_q];
    assign full      = pending_q == PW'(MAX_PENDING);
    assign wbm_dat_i = wbs_dat_o;
    assign wbs_cyc_i = owned & cyc_g;
    assign wbs_stb_i = owned & cyc_g & wbm_stb_o[gnt_q] & ~full;
    assign wbs_we_i  = wbm_we_o[gnt_q];
    assign wbs_adr_i = wbm_adr_o[ADR_W*int'(gnt_q) +: ADR_W];
    assign wbs_sel_i = wbm_sel_o[SEL_W*int'(gnt_q) +: SEL_W];
    assign wbs_dat_i = wbm_dat_o[DAT_W*int'(gnt_q) +: DAT_W];
    assign accept    = wbs_stb_i & ~wbs_stall_o;
    // Acks with nothing outstanding are stray and must not underflow the count.
    assign retire    = wbs_ack_o & (pending_q != '0);

    always_comb begin
        wbm_stall_i = '1;
        wbm_ack_i   = '0;
        if (owned) wbm_stall_i[gnt_q] = wbs_stall_o | full;
        wbm_ack_i[gnt_q] = wbs_ack_o & owned;
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        pending_d = pending_q + PW'(accept) - PW'(retire);
        if (!owned && pick_valid) begin
            state_d = OWNED;
            gnt_d   = pick_idx;
            last_d  = pick_idx;
        end
        if (owned && !cyc_g) begin
            state_d   = IDLE;
            pending_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_q    <= IW'(MASTER_NUM - 1);
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_wbx_arbiter.sv
// tb_wbx_arbiter: directed checks of arbitration order, pending cap, abandon and reset behaviour.
module tb_wbx_arbiter;
    localparam int M = 3;

    logic          clk = 1'b0, rst;
    logic [M-1:0]  cyc, stb, we;
    logic [32*M-1:0] adr, dat;
    logic [4*M-1:0]  sel;
    logic [31:0]   m_dat, s_adr, s_dat_w, s_dat;
    logic [M-1:0]  stall, ack;
    logic          s_cyc, s_stb, s_we, s_stall, s_ack;
    logic [3:0]    s_sel;
    int            checks = 0, errors = 0, acc;

    wbx_arbiter #(.MASTER_NUM(M), .MAX_PENDING(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_adr_o   (adr),
        .wbm_sel_o   (sel),
        .wbm_dat_o   (dat),
        .wbm_dat_i   (m_dat),
        .wbm_stall_i (stall),
        .wbm_ack_i   (ack),
        .wbs_cyc_i   (s_cyc),
        .wbs_stb_i   (s_stb),
        .wbs_we_i    (s_we),
        .wbs_adr_i   (s_adr),
        .wbs_sel_i   (s_sel),
        .wbs_dat_i   (s_dat_w),
        .wbs_dat_o   (s_dat),
        .wbs_stall_o (s_stall),
        .wbs_ack_o   (s_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] adr_of(input int m);
        return 32'h1000_0000 * 32'(m + 1);
    endfunction

    function automatic logic [31:0] dat_of(input int m);
        return 32'hD000_0000 + 32'(m);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cyc = '0; stb = '0; we = 3'b010; sel = 12'h421;
        s_stall = 1'b0; s_ack = 1'b0; s_dat = 32'hCAFE_F00D;
        for (int m = 0; m < M; m++) begin
            adr[32*m +: 32] = adr_of(m);
            dat[32*m +: 32] = dat_of(m);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0; #1;
        check("rst_cyc", 32'(s_cyc), 0);
        check("rst_stb", 32'(s_stb), 0);
        check("rst_stall", 32'(stall), 3'b111);
        check("rst_ack", 32'(ack), 0);
        // masters 0 and 1 request together
        @(negedge clk); cyc = 3'b011; #1;
        check("arb_latency_stall", 32'(stall), 3'b111);
        @(negedge clk); #1;
        check("gnt0_adr", s_adr, adr_of(0));
        check("gnt0_cyc", 32'(s_cyc), 1);
        check("gnt0_stall", 32'(stall), 3'b110);
        cyc = 3'b010; #1;
        check("drop_cyc", 32'(s_cyc), 0);
        @(negedge clk); #1;
        check("idle_gap_stall", 32'(stall), 3'b111);
        check("idle_gap_cyc", 32'(s_cyc), 0);
        @(negedge clk); #1;
        check("gnt1_adr", s_adr, adr_of(1));
        check("gnt1_stall", 32'(stall), 3'b101);
        check("gnt1_sel", 32'(s_sel), 4'h2);
        check("gnt1_dat", s_dat_w, dat_of(1));
        check("gnt1_we", 32'(s_we), 1);
        cyc = '0;
        // pending cap with a never-acking slave
        @(negedge clk); cyc = 3'b001; stb = 3'b001;
        @(negedge clk); #1;
        check("gnt_after_1", s_adr, adr_of(0));
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (s_stb && !s_stall) acc++;
            @(negedge clk); #1;
        end
        check("cap_accepts", 32'(acc), 4);
        check("cap_stall", 32'(stall), 3'b111);
        check("cap_stb", 32'(s_stb), 0);
        check("cap_pending", 32'(dut.pending_q), 4);
        s_ack = 1'b1; #1;
        check("ack_fwd", 32'(ack), 3'b001);
        check("dat_bcast", m_dat, 32'hCAFE_F00D);
        @(negedge clk); s_ack = 1'b0; #1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (s_stb && !s_stall) acc++;
            @(negedge clk); #1;
        end
        check("one_more_accept", 32'(acc), 1);
        check("refull_pending", 32'(dut.pending_q), 4);
        // accept and ack in the same cycle
        stb = '0; s_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("drain_pending", 32'(dut.pending_q), 2);
        stb = 3'b001; #1;
        check("same_cycle_stb", 32'(s_stb), 1);
        @(negedge clk); s_ack = 1'b0; stb = '0; #1;
        check("same_cycle_pending", 32'(dut.pending_q), 2);
        // abandon with three outstanding
        stb = 3'b001;
        @(negedge clk); stb = '0; #1;
        check("pre_abandon_pending", 32'(dut.pending_q), 3);
        cyc = '0;
        @(negedge clk); s_ack = 1'b1; #1;
        check("abandon_pending", 32'(dut.pending_q), 0);
        check("abandon_stall", 32'(stall), 3'b111);
        check("late_ack", 32'(ack), 0);
        @(negedge clk); s_ack = 1'b0; #1;
        check("no_underflow", 32'(dut.pending_q), 0);
        // reset while owned restores master 0 priority
        cyc = 3'b110;
        @(negedge clk); #1;
        check("pre_rst_gnt", s_adr, adr_of(1));
        rst = 1'b1;
        @(negedge clk); #1;
        check("mid_rst_stall", 32'(stall), 3'b111);
        check("mid_rst_cyc", 32'(s_cyc), 0);
        rst = 1'b0; cyc = 3'b111;
        @(negedge clk); #1;
        check("post_rst_gnt", s_adr, adr_of(0));
        // fairness over repeated short cycles
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_%0d", k), s_adr, adr_of(k % 3));
            cyc = 3'b111 & ~3'(1 << (k % 3));
            @(negedge clk); cyc = 3'b111;
            @(negedge clk); #1;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
